// File: rtl/game2048_pkg.sv
// game2048_pkg: shared state/direction codes, key bit positions and controller FSM states.
package game2048_pkg;
    localparam logic [1:0] ST_INIT = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_WIN  = 2'b10;
    localparam logic [1:0] ST_LOSE = 2'b11;
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;
    localparam int KEY_UP    = 3;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_LEFT  = 1;
    localparam int KEY_RIGHT = 0;
    typedef enum logic [2:0] {INIT_S0, INIT_S1, IDLE, MOVE, SPAWN, CHECK, WIN, LOSE} fsm_t;
    function automatic logic [1:0] state_code(fsm_t s);
        return (s == INIT_S0 || s == INIT_S1) ? ST_INIT :
               (s == WIN) ? ST_WIN : (s == LOSE) ? ST_LOSE : ST_PLAY;
    endfunction
endpackage

// File: rtl/game_ctrl2048_if.sv
// game_ctrl2048_if: key pins, board-engine handshake and game status between controller and engine.
//   master (controller): drives mv_req/mv_dir/spawn_req/step/score/state; reads keys, dones, flags.
//   slave  (engine side): the mirror image.
interface game_ctrl2048_if #(
    parameter int STEP_W  = 8,
    parameter int SCORE_W = 8
);
    logic [3:0]         keyin;
    logic               mv_req;
    logic [1:0]         mv_dir;
    logic               mv_done;
    logic               mv_changed;
    logic [SCORE_W-1:0] mv_gain;
    logic               spawn_req;
    logic               spawn_done;
    logic               has_2048;
    logic               has_empty;
    logic               can_merge;
    logic [STEP_W-1:0]  step;
    logic [SCORE_W-1:0] score;
    logic [1:0]         state;
    modport master (
        input  keyin, mv_done, mv_changed, mv_gain, spawn_done, has_2048, has_empty, can_merge,
        output mv_req, mv_dir, spawn_req, step, score, state
    );
    modport slave (
        output keyin, mv_done, mv_changed, mv_gain, spawn_done, has_2048, has_empty, can_merge,
        input  mv_req, mv_dir, spawn_req, step, score, state
    );
endinterface

// File: rtl/key_debounce2048.sv
// key_debounce2048: registers raw keys and emits one key_evt pulse per stable one-hot press.
//   clk, rst   : clock, synchronous active-high reset
//   i_keyin    : raw key levels (bit3 up, bit2 down, bit1 left, bit0 right)
//   o_key_evt  : one-cycle accepted-key pulse
//   o_key_dir  : direction of the registered key code
module key_debounce2048
    import game2048_pkg::*;
#(
    parameter int DEBOUNCE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] i_keyin,
    output logic       o_key_evt,
    output logic [1:0] o_key_dir
);
    logic [3:0] r_keyin_q;
    logic [3:0] r_cnt;
    logic       r_armed;
    logic       w_stable;

    // the sample about to be taken matching the held one means the key stayed put for another cycle
    assign w_stable  = (i_keyin == r_keyin_q) && $onehot(r_keyin_q);
    assign o_key_evt = r_armed && (r_cnt == 4'(DEBOUNCE));
    assign o_key_dir = r_keyin_q[KEY_UP]   ? DIR_UP   :
                       r_keyin_q[KEY_DOWN] ? DIR_DOWN :
                       r_keyin_q[KEY_LEFT] ? DIR_LEFT : DIR_RIGHT;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_keyin_q <= '0;
            r_cnt     <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_keyin_q <= i_keyin;
            // saturate so a long hold never wraps back through DEBOUNCE
            r_cnt     <= !w_stable ? 4'd0 : r_cnt + 4'(~&r_cnt);
            // re-arm only after a full release, so a held key fires once
            r_armed   <= (r_keyin_q == 4'd0) ? 1'b1 : (o_key_evt ? 1'b0 : r_armed);
        end
    end
endmodule

// File: rtl/game_ctrl2048.sv
// game_ctrl2048: 2048 game-flow controller (move -> spawn -> check sequencing, step/score, game state).
//   clk, rst : clock, synchronous active-high reset
//   bus      : master side of game_ctrl2048_if (keys, move/spawn handshakes, status flags, counters)
module game_ctrl2048
    import game2048_pkg::*;
#(
    parameter int DEBOUNCE = 2,
    parameter int STEP_W   = 8,
    parameter int SCORE_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    game_ctrl2048_if.master   bus
);
    fsm_t               r_state;
    fsm_t               w_next;
    logic               r_mv_req;
    logic [1:0]         r_mv_dir;
    logic               r_spawn_req;
    logic               r_pend_v;
    logic [1:0]         r_pend_dir;
    logic [STEP_W-1:0]  r_step;
    logic [SCORE_W-1:0] r_score;
    logic               w_key_evt;
    logic [1:0]         w_key_dir;
    logic               w_mv_fire;
    logic               w_spawn_fire;
    logic [SCORE_W:0]   w_sum;

    key_debounce2048 #(.DEBOUNCE(DEBOUNCE)) u_key (
        .clk       (clk),
        .rst       (rst),
        .i_keyin   (bus.keyin),
        .o_key_evt (w_key_evt),
        .o_key_dir (w_key_dir)
    );

    // done pulses count only in the state that owns the matching request
    assign w_mv_fire    = (r_state == MOVE) && bus.mv_done;
    assign w_spawn_fire = (r_state == INIT_S0 || r_state == INIT_S1 || r_state == SPAWN) && bus.spawn_done;
    assign w_sum        = {1'b0, r_score} + {1'b0, bus.mv_gain};

    always_comb begin
        w_next = r_state;
        case (r_state)
            INIT_S0: w_next = bus.spawn_done ? INIT_S1 : INIT_S0;
            INIT_S1: w_next = bus.spawn_done ? IDLE : INIT_S1;
            IDLE:    w_next = (r_pend_v || w_key_evt) ? MOVE : IDLE;
            MOVE:    w_next = !bus.mv_done ? MOVE : (bus.mv_changed ? SPAWN : IDLE);
            SPAWN:   w_next = bus.spawn_done ? CHECK : SPAWN;
            CHECK:   w_next = bus.has_2048 ? WIN : ((bus.has_empty || bus.can_merge) ? IDLE : LOSE);
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= INIT_S0;
            r_mv_req    <= 1'b0;
            r_mv_dir    <= DIR_UP;
            r_spawn_req <= 1'b0;
            r_pend_v    <= 1'b0;
            r_pend_dir  <= DIR_UP;
            r_step      <= '0;
            r_score     <= '0;
        end else begin
            r_state     <= w_next;
            r_mv_req    <= (w_next == MOVE);
            // the fire term drops the request for a cycle between the two starting tiles
            r_spawn_req <= (w_next == INIT_S0 || w_next == INIT_S1 || w_next == SPAWN) && !w_spawn_fire;
            if (r_state == IDLE && w_next == MOVE)
                r_mv_dir <= r_pend_v ? r_pend_dir : w_key_dir;
            if (w_next == WIN || w_next == LOSE)
                r_pend_v <= 1'b0;
            else if (w_key_evt && r_state != IDLE) begin
                r_pend_v   <= 1'b1;
                r_pend_dir <= w_key_dir;
            end else if (r_state == IDLE && r_pend_v)
                r_pend_v <= 1'b0;
            if (w_mv_fire && bus.mv_changed) begin
                r_step  <= r_step + STEP_W'(~&r_step);
                r_score <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
            end
        end
    end

    assign bus.mv_req    = r_mv_req;
    assign bus.mv_dir    = r_mv_dir;
    assign bus.spawn_req = r_spawn_req;
    assign bus.step      = r_step;
    assign bus.score     = r_score;
    assign bus.state     = state_code(r_state);
endmodule
